// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a length-prefixed, XOR-checksummed program image as a
//             byte stream and writes 32-bit little-endian words into the
//             instruction RAM while holding the CPU core in reset.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_start,
    input  logic        load_abort,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] C_DEPTH = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5
    } state_t;

    state_t      state_q,      state_d;
    logic [15:0] len_q,        len_d;
    logic [15:0] word_idx_q,   word_idx_d;
    logic [1:0]  byte_cnt_q,   byte_cnt_d;
    logic [31:0] word_q,       word_d;
    logic [7:0]  chk_q,        chk_d;
    logic        imem_we_q,    imem_we_d;
    logic [31:0] imem_addr_q,  imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        done_q,       done_d;
    logic        err_q,        err_d;

    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_new_len;
    logic [31:0] w_word;

    // Byte acceptance: only in byte-consuming states, and never in an abort cycle
    always_comb begin
        w_ready = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: w_ready = 1'b1;
            default:                           w_ready = 1'b0;
        endcase
        if (load_abort) begin
            w_ready = 1'b0;
        end
    end

    assign w_accept  = rx_valid && w_ready;
    assign w_new_len = {rx_data, len_q[7:0]};

    // Word being assembled with the incoming byte placed in its lane
    always_comb begin
        w_word                     = word_q;
        w_word[8*byte_cnt_q +: 8]  = rx_data;
    end

    // Next-state and datapath update; abort is applied last so it overrides all
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        chk_d        = chk_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_LEN_LO;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    len_d      = 16'd0;
                    word_idx_d = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_d     = 32'd0;
                    chk_d      = 8'd0;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    len_d = w_new_len;
                    if (w_new_len == 16'd0) begin
                        state_d = S_CHK;
                    end else if ({1'b0, w_new_len} > C_DEPTH) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    word_d     = w_word;
                    chk_d      = chk_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Register the write so the strobe appears in the WRITE cycle
                        state_d      = S_WRITE;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        imem_wdata_d = w_word;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (({1'b0, word_idx_q} + 17'd1) < {1'b0, len_q}) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    state_d = S_IDLE;
                    if (rx_data == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            done_d    = 1'b0;
            imem_we_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            chk_q        <= 8'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            chk_q        <= chk_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready   = w_ready;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign cpu_hold   = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire
